// File: rtl/bus_xfer_sequencer_pkg.sv
// Shared codes, sizes and FSM state type for the bus transfer encoder/sequencer pair.
// Keeping the codes here stops the source and destination sides from drifting apart.
package bus_xfer_sequencer_pkg;

    localparam int CODE_W  = 5;
    localparam int NUM_SRC = 24;
    localparam int NUM_DST = 25;

    // Source codes (R0..R15 are 0..15)
    localparam logic [CODE_W-1:0] SRC_HI     = 5'd16;
    localparam logic [CODE_W-1:0] SRC_LO     = 5'd17;
    localparam logic [CODE_W-1:0] SRC_ZHIGH  = 5'd18;
    localparam logic [CODE_W-1:0] SRC_ZLOW   = 5'd19;
    localparam logic [CODE_W-1:0] SRC_PC     = 5'd20;
    localparam logic [CODE_W-1:0] SRC_MDR    = 5'd21;
    localparam logic [CODE_W-1:0] SRC_INPORT = 5'd22;
    localparam logic [CODE_W-1:0] SRC_C      = 5'd23;

    // Destination codes (R0..R15 are 0..15)
    localparam logic [CODE_W-1:0] DST_HI      = 5'd16;
    localparam logic [CODE_W-1:0] DST_LO      = 5'd17;
    localparam logic [CODE_W-1:0] DST_PC      = 5'd18;
    localparam logic [CODE_W-1:0] DST_IR      = 5'd19;
    localparam logic [CODE_W-1:0] DST_Y       = 5'd20;
    localparam logic [CODE_W-1:0] DST_Z       = 5'd21;
    localparam logic [CODE_W-1:0] DST_MAR     = 5'd22;
    localparam logic [CODE_W-1:0] DST_MDR     = 5'd23;
    localparam logic [CODE_W-1:0] DST_OUTPORT = 5'd24;

    // Z -> {LO, HI} pair move: low half first, then high half
    localparam logic [CODE_W-1:0] PAIR_SRC_FIRST  = SRC_ZLOW;
    localparam logic [CODE_W-1:0] PAIR_DST_FIRST  = DST_LO;
    localparam logic [CODE_W-1:0] PAIR_SRC_SECOND = SRC_ZHIGH;
    localparam logic [CODE_W-1:0] PAIR_DST_SECOND = DST_HI;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_LOAD  = 2'd2,
        ST_ERR   = 2'd3
    } xfer_state_t;

    function automatic logic codes_in_range(input logic [CODE_W-1:0] src,
                                            input logic [CODE_W-1:0] dst);
        return (int'(src) < NUM_SRC) && (int'(dst) < NUM_DST);
    endfunction

endpackage

// File: rtl/bus_xfer_sequencer_onehot_dec.sv
// Parameterized binary-to-one-hot decoder with enable; codes >= N decode to all zeros.
module onehot_dec #(
    parameter int N = 24,
    parameter int W = 5
) (
    input  logic [W-1:0] code,
    input  logic         en,
    output logic [N-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = en && (code == W'(i));
        end
    end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Destination-side transfer sequencer: drive source, settle, pulse one load enable.
// Optional Z->{LO,HI} pair move compiled in with BUS_XFER_PAIR_EN.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ready for a request; all enables off
//   ST_DRIVE | source drives the bus for SETTLE_CYCLES cycles
//   ST_LOAD  | source held, one destination load enable for one cycle
//   ST_ERR   | rejected request; err pulse with all enables off
module bus_xfer_sequencer
    import bus_xfer_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CODE_W-1:0]   req_src,
    input  logic [CODE_W-1:0]   req_dst,
    input  logic                req_pair,
    output logic [CODE_W-1:0]   bus_sel,
    output logic [NUM_SRC-1:0]  src_out,
    output logic [NUM_DST-1:0]  dst_in,
    output logic                done,
    output logic                err
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    xfer_state_t       state, state_d;
    logic [CODE_W-1:0] src_q, src_d;
    logic [CODE_W-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              src_active;
    logic              pair_first;
`ifdef BUS_XFER_PAIR_EN
    logic              pair_q, pair_d;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= ST_IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            cnt    <= '0;
`ifdef BUS_XFER_PAIR_EN
            pair_q <= 1'b0;
`endif
        end else begin
            state  <= state_d;
            src_q  <= src_d;
            dst_q  <= dst_d;
            cnt    <= cnt_d;
`ifdef BUS_XFER_PAIR_EN
            pair_q <= pair_d;
`endif
        end
    end

`ifdef BUS_XFER_PAIR_EN
    assign pair_first = pair_q;
`else
    assign pair_first = 1'b0;
`endif

    always_comb begin
        state_d = state;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt;
`ifdef BUS_XFER_PAIR_EN
        pair_d  = pair_q;
`endif
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    src_d = req_src;
                    dst_d = req_dst;
                    cnt_d = '0;
`ifdef BUS_XFER_PAIR_EN
                    pair_d = req_pair;
                    if (req_pair) begin
                        src_d   = PAIR_SRC_FIRST;
                        dst_d   = PAIR_DST_FIRST;
                        state_d = ST_DRIVE;
                    end else if (!codes_in_range(req_src, req_dst)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DRIVE;
                    end
`else
                    if (req_pair || !codes_in_range(req_src, req_dst)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DRIVE;
                    end
`endif
                end
            end
            ST_DRIVE: begin
                if (cnt == CNT_LAST) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
`ifdef BUS_XFER_PAIR_EN
                // first half done: retarget to the high half without returning to idle
                if (pair_q) begin
                    src_d   = PAIR_SRC_SECOND;
                    dst_d   = PAIR_DST_SECOND;
                    pair_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_DRIVE;
                end
`endif
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign src_active = (state == ST_DRIVE) || (state == ST_LOAD);
    assign req_ready  = (state == ST_IDLE);
    assign bus_sel    = src_active ? src_q : '0;
    assign done       = (state == ST_LOAD) && !pair_first;
    assign err        = (state == ST_ERR);

    onehot_dec #(.N(NUM_SRC), .W(CODE_W)) u_src_dec (
        .code   (src_q),
        .en     (src_active),
        .onehot (src_out)
    );

    onehot_dec #(.N(NUM_DST), .W(CODE_W)) u_dst_dec (
        .code   (dst_q),
        .en     (state == ST_LOAD),
        .onehot (dst_in)
    );

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Bench for bus_xfer_sequencer: two instances (settle 1 and 3) against a cycle-offset
// reference model; directed test-plan scenarios followed by random traffic.
module tb_bus_xfer_sequencer;
    import bus_xfer_sequencer_pkg::*;

`ifdef BUS_XFER_PAIR_EN
    localparam bit PAIR_EN = 1'b1;
`else
    localparam bit PAIR_EN = 1'b0;
`endif
    localparam int S_A = 1;
    localparam int S_B = 3;

    typedef struct packed {
        logic        ready;
        logic [4:0]  bus_sel;
        logic [23:0] src_out;
        logic [24:0] dst_in;
        logic        done;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_valid;
    logic        req_pair;
    logic [4:0]  req_src;
    logic [4:0]  req_dst;

    logic        req_ready_o [2];
    logic [4:0]  bus_sel_o   [2];
    logic [23:0] src_out_o   [2];
    logic [24:0] dst_in_o    [2];
    logic        done_o      [2];
    logic        err_o       [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // model state per instance: k = cycle offset within the current transfer (0 = idle)
    int         k      [2];
    int         ln     [2];
    int         sv     [2];
    logic [4:0] m_src  [2];
    logic [4:0] m_dst  [2];
    logic       m_pair [2];
    logic       m_bad  [2];

    always #5 clk = ~clk;

    bus_xfer_sequencer #(.SETTLE_CYCLES(S_A)) u_dut_a (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready_o[0]),
        .req_src(req_src), .req_dst(req_dst), .req_pair(req_pair),
        .bus_sel(bus_sel_o[0]), .src_out(src_out_o[0]), .dst_in(dst_in_o[0]),
        .done(done_o[0]), .err(err_o[0])
    );

    bus_xfer_sequencer #(.SETTLE_CYCLES(S_B)) u_dut_b (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready_o[1]),
        .req_src(req_src), .req_dst(req_dst), .req_pair(req_pair),
        .bus_sel(bus_sel_o[1]), .src_out(src_out_o[1]), .dst_in(dst_in_o[1]),
        .done(done_o[1]), .err(err_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int seq_len(input int s, input logic pair, input logic bad);
        if (bad)  return 1;
        if (pair) return 2 * s + 2;
        return s + 1;
    endfunction

    function automatic exp_t expect_at(input int s, input int kk, input logic [4:0] src,
                                       input logic [4:0] dst, input logic pair, input logic bad);
        exp_t       e;
        int         ph;
        logic [4:0] es;
        logic [4:0] ed;
        logic       load;
        e = '0;
        if (kk == 0) begin
            e.ready = 1'b1;
            return e;
        end
        if (bad) begin
            e.err = 1'b1;
            return e;
        end
        ph = kk;
        es = src;
        ed = dst;
        if (pair) begin
            if (kk <= s + 1) begin
                es = 5'd19;
                ed = 5'd17;
            end else begin
                es = 5'd18;
                ed = 5'd16;
                ph = kk - (s + 1);
            end
        end
        load      = (ph == s + 1);
        e.bus_sel = es;
        e.src_out = 24'(1) << es;
        if (load) e.dst_in = 25'(1) << ed;
        e.done    = load && !(pair && kk == s + 1);
        return e;
    endfunction

    task automatic step();
        exp_t e;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                k[i] = 0;
            end else if (k[i] == 0) begin
                if (req_valid) begin
                    m_src[i]  = req_src;
                    m_dst[i]  = req_dst;
                    m_pair[i] = req_pair;
                    m_bad[i]  = req_pair ? !PAIR_EN : (req_src > 5'd23 || req_dst > 5'd24);
                    ln[i]     = seq_len(sv[i], m_pair[i], m_bad[i]);
                    k[i]      = 1;
                end
            end else if (k[i] < ln[i]) begin
                k[i]++;
            end else begin
                k[i] = 0;
            end
        end
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            e = expect_at(sv[i], k[i], m_src[i], m_dst[i], m_pair[i], m_bad[i]);
            check($sformatf("dut%0d req_ready", i), 32'(req_ready_o[i]), 32'(e.ready));
            check($sformatf("dut%0d bus_sel", i),   32'(bus_sel_o[i]),   32'(e.bus_sel));
            check($sformatf("dut%0d src_out", i),   32'(src_out_o[i]),   32'(e.src_out));
            check($sformatf("dut%0d dst_in", i),    32'(dst_in_o[i]),    32'(e.dst_in));
            check($sformatf("dut%0d done", i),      32'(done_o[i]),      32'(e.done));
            check($sformatf("dut%0d err", i),       32'(err_o[i]),       32'(e.err));
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] s, input logic [4:0] d,
                         input logic p, input logic c);
        req_valid = v;
        req_src   = s;
        req_dst   = d;
        req_pair  = p;
        clr       = c;
        step();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        sv[0] = S_A;
        sv[1] = S_B;
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; ln[i] = 0; m_src[i] = '0; m_dst[i] = '0; m_pair[i] = 1'b0; m_bad[i] = 1'b0;
        end
        req_valid = 1'b0; req_src = '0; req_dst = '0; req_pair = 1'b0; clr = 1'b1;
        step();
        step();

        drive(1'b1, 5'd3, 5'd7, 1'b0, 1'b0);      // plain transfer
        idle(6);
        drive(1'b1, 5'd30, 5'd31, 1'b1, 1'b0);    // pair move, codes ignored
        idle(10);
        drive(1'b1, 5'd25, 5'd2, 1'b0, 1'b0);     // bad source
        idle(3);
        drive(1'b1, 5'd4, 5'd25, 1'b0, 1'b0);     // bad destination
        idle(3);
        drive(1'b1, 5'd23, 5'd24, 1'b0, 1'b0);    // highest legal codes
        idle(6);
        drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0);      // back-to-back with valid held
        for (int j = 0; j < 8; j++) drive(1'b1, 5'd4, 5'd9, 1'b0, 1'b0);
        idle(6);
        drive(1'b1, 5'd6, 5'd6, 1'b0, 1'b0);      // clr during DRIVE
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
        idle(6);
        drive(1'b1, 5'd20, 5'd22, 1'b0, 1'b0);    // PC -> MAR
        idle(6);

        for (int j = 0; j < 800; j++) begin
            logic       v, p, c;
            logic [4:0] s, d;
            v = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 23)) : 5'($urandom_range(0, 31));
            d = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 24)) : 5'($urandom_range(0, 31));
            p = ($urandom_range(0, 7) == 0);
            c = ($urandom_range(0, 39) == 0);
            drive(v, s, d, p, c);
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_xfer_sequencer.md
# bus_xfer_sequencer

Sequences one register-to-register transfer across the shared 32-bit datapath bus. It is the destination-side counterpart of the source encoder. From a requested source/destination code pair it drives the encoded bus select and the one-hot source out-enable, holds the source for a settle period, then pulses exactly one destination load enable. A paired mode moves the 64-bit Z result into LO then HI as two back-to-back transfers.

## Interface
- SETTLE_CYCLES, 1: cycles the source drives the bus before the load cycle; must be ≥1.
- clk  in  1  datapath clock; all state changes on rising edge.
- clr  in  1  reset, synchronous, active-high.
- req_valid  in  1  transfer request.
- req_ready  out  1  high only in IDLE; a transfer is accepted on an edge where req_valid && req_ready.
- req_src  in  5  source code: R0–R15 = 0–15, HI 16, LO 17, Zhigh 18, Zlow 19, PC 20, MDR 21, InPort 22, C 23.
- req_dst  in  5  destination code: R0–R15 = 0–15, HI 16, LO 17, PC 18, IR 19, Y 20, Z 21, MAR 22, MDR 23, OutPort 24.
- req_pair  in  1  Z→{LO,HI} pair move; when set, req_src and req_dst are ignored.
- bus_sel  out  5  encoded bus mux select; 0 when no source is active.
- src_out  out  24  one-hot source out-enable, bit index = source code.
- dst_in  out  25  one-hot destination load enable, bit index = destination code.
- done  out  1  one-cycle pulse in the final LOAD cycle.
- err  out  1  one-cycle pulse on a rejected request.

## Operation
- FSM states: IDLE, DRIVE, LOAD, ERR.
- IDLE: on acceptance, latch src, dst and pair flag; clear the settle counter.
  - Invalid request (src > 23, dst > 24, or pair with the feature compiled out) → ERR.
  - Otherwise → DRIVE.
- DRIVE: src_out = onehot(src), bus_sel = src, dst_in = 0. Counter increments each cycle; after SETTLE_CYCLES cycles → LOAD.
- LOAD: src_out and bus_sel are held, and dst_in = onehot(dst) for exactly one cycle.
  - Pair first half (Zlow 19 → LO 17): next latch Zhigh 18 → HI 16, clear the counter, → DRIVE. No done pulse.
  - Otherwise: done = 1, → IDLE.
- ERR: err = 1 for one cycle with all enables 0, then → IDLE.
- src == dst is legal; the register reloads its own value.
- All outputs are decoded from registered state. No combinational path runs from req_* to any enable.
- At most one bit of src_out and at most one bit of dst_in is high in any cycle.

## Timing
- Reset values: req_ready 1 (state IDLE); bus_sel 0, src_out 0, dst_in 0, done 0, err 0.
- clr has priority over everything. Asserted in any cycle, the FSM is in IDLE with all enables 0 after the next edge. A load enable already high in that cycle is not retracted.
- A transfer accepted at edge 0:
  - DRIVE occupies cycles 1..S, where S = SETTLE_CYCLES.
  - LOAD is cycle S+1.
  - req_ready is high again in cycle S+2.
- Pair transfer: first LOAD in cycle S+1, second DRIVE in cycles S+2..2S+1, second LOAD and done in cycle 2S+2.
- Invalid request accepted at edge 0: err in cycle 1, req_ready high in cycle 2.
- With req_valid held continuously, the next request is accepted at the first edge where req_ready is high. There are no bubbles beyond that.

## Configuration
- BUS_XFER_PAIR_EN defined: the pair mode is compiled in as described above.
- BUS_XFER_PAIR_EN undefined:
  - The req_pair port remains.
  - Any accepted request with req_pair = 1 takes the ERR path.
  - No pair-sequencing logic is present.

## Structure
- Shared package holds:
  - source and destination code constants;
  - NUM_SRC = 24 and NUM_DST = 25;
  - the FSM state enum;
  - the pair codes (Zlow, LO, Zhigh, HI).
- The encoder side uses the same package so the codes cannot diverge.
- One sub-module, onehot_dec, is a parameterized N-bit binary-to-one-hot decoder with enable. It is instantiated twice: once for src_out and once for dst_in.

## Test plan
1. S=1, src 3, dst 7, accepted edge 0:
   - cycle 1: bus_sel = 3, src_out = 1<<3, dst_in = 0;
   - cycle 2: dst_in = 1<<7, done = 1;
   - cycle 3: req_ready = 1.
2. S=1, pair with BUS_XFER_PAIR_EN defined:
   - cycle 2: bus_sel = 19, dst_in = 1<<17, done = 0;
   - cycle 3: bus_sel = 18, dst_in = 0;
   - cycle 4: dst_in = 1<<16, done = 1.
   With the macro undefined: err in cycle 1, no enables.
3. src 25, dst 2: err = 1 in cycle 1; src_out, dst_in and bus_sel are all 0 throughout; req_ready = 1 in cycle 2.
4. S=1, req_valid held high with two queued requests: second accepted at edge 3; its LOAD falls in cycle 5.
5. clr asserted in cycle 1 (DRIVE): cycle 2 shows all enables 0 and req_ready = 1; no done or dst_in pulse ever occurs for that transfer.
6. SETTLE_CYCLES = 3, src 20 (PC), dst 22 (MAR): src_out = 1<<20 in cycles 1–4; dst_in = 1<<22 and done in cycle 4 only.
